// File: rtl/uart_wave_cmd.sv
// UART 8N1 command receiver/decoder driving per-channel wave-select and noise-enable registers.
// Define RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_wave_cmd #(
    parameter int unsigned CLK_HZ     = 25000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned NUM_CH     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [3*NUM_CH-1:0]   wave_select,
    output logic [NUM_CH-1:0]     white_noise_en,
    output logic [3:0]            ch_sel,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  cmd_err
);

    localparam int unsigned DIV = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CW  = $clog2(OVERSAMPLE + 2);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
`ifdef RX_MAJORITY_EN
    localparam logic [CW-1:0] START_TGT = CW'(OVERSAMPLE / 2 + 1);
`else
    localparam logic [CW-1:0] START_TGT = CW'(OVERSAMPLE / 2);
`endif
    localparam logic [CW-1:0] BIT_TGT   = CW'(OVERSAMPLE);
    localparam logic [4:0]    NUM_CH_W  = 5'(NUM_CH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t              state_q, state_d;
    logic                rx_meta_q, rx_sync_q;
    logic [DW-1:0]       div_q, div_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          bitn_q, bitn_d;
    logic [7:0]          shift_q, shift_d;
    logic [7:0]          rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                frame_err_q, frame_err_d;
    logic [3*NUM_CH-1:0] wave_q, wave_d;
    logic [NUM_CH-1:0]   noise_q, noise_d;
    logic [3:0]          ch_q, ch_d;
    logic                cmd_err_q, cmd_err_d;
    logic [1:0]          smp_q, smp_d;

    logic                tick;
    logic [CW-1:0]       cnt_nx;
    logic [CW-1:0]       tgt;
    logic                at_sample;
    logic                sample;

    // Receive FSM and tick generation
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        bitn_d      = bitn_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        smp_d       = smp_q;

        tick      = (div_q == DIV_LAST);
        cnt_nx    = cnt_q + 1'b1;
        tgt       = (state_q == S_START) ? START_TGT : BIT_TGT;
        at_sample = tick && (cnt_nx == tgt);

`ifdef RX_MAJORITY_EN
        // Two early samples are held; the third is the live line at the decision tick.
        if (tick && (cnt_nx == tgt - 2'd2)) smp_d[0] = rx_sync_q;
        if (tick && (cnt_nx == tgt - 2'd1)) smp_d[1] = rx_sync_q;
        sample = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_sync_q) | (smp_q[1] & rx_sync_q);
`else
        sample = rx_sync_q;
`endif

        if (state_q == S_IDLE) begin
            div_d = '0;
        end else if (tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end

        if (tick) begin
            cnt_d = at_sample ? '0 : cnt_nx;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) state_d = S_START;
            end
            S_START: begin
                if (at_sample) begin
                    bitn_d  = '0;
                    state_d = sample ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (at_sample) begin
                    shift_d = {sample, shift_q[7:1]};
                    bitn_d  = bitn_q + 3'd1;
                    if (bitn_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (at_sample) begin
                    if (sample) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command decode on the rx_valid cycle
    always_comb begin
        logic       wr_wave;
        logic       tog;
        logic [2:0] code;

        wave_d    = wave_q;
        noise_d   = noise_q;
        ch_d      = ch_q;
        cmd_err_d = 1'b0;
        wr_wave   = 1'b0;
        tog       = 1'b0;
        code      = 3'd0;

        if (rx_valid_q) begin
            case (rx_data_q)
                8'h51: begin wr_wave = 1'b1; code = 3'd0; end
                8'h54: begin wr_wave = 1'b1; code = 3'd1; end
                8'h53: begin wr_wave = 1'b1; code = 3'd2; end
                8'h49: begin wr_wave = 1'b1; code = 3'd3; end
                8'h4E: tog = 1'b1;
                8'h6E: noise_d = '0;
                default: begin
                    if (rx_data_q[7:4] == 4'h3 && rx_data_q[3:0] <= 4'h9) begin
                        if ({1'b0, rx_data_q[3:0]} < NUM_CH_W) begin
                            ch_d = rx_data_q[3:0];
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            endcase
        end

        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ch_q == 4'(k)) begin
                if (wr_wave) wave_d[3*k +: 3] = code;
                if (tog)     noise_d[k]       = ~noise_q[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            div_q       <= '0;
            cnt_q       <= '0;
            bitn_q      <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wave_q      <= '0;
            noise_q     <= '0;
            ch_q        <= '0;
            cmd_err_q   <= 1'b0;
            smp_q       <= '1;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            bitn_q      <= bitn_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            wave_q      <= wave_d;
            noise_q     <= noise_d;
            ch_q        <= ch_d;
            cmd_err_q   <= cmd_err_d;
            smp_q       <= smp_d;
        end
    end

    assign wave_select    = wave_q;
    assign white_noise_en = noise_q;
    assign ch_sel         = ch_q;
    assign rx_data        = rx_data_q;
    assign rx_valid       = rx_valid_q;
    assign frame_err      = frame_err_q;
    assign cmd_err        = cmd_err_q;

endmodule
